// File: rtl/stopwatch_core.sv
// stopwatch_core: ss.hh packed-BCD stopwatch driven by start/stop, lap and zero buttons.
// Buttons are synchronized and edge-detected; a prescaler produces one tick per hundredth.
module stopwatch_core #(
    parameter int TICK_DIV = 1000000,
    parameter int PRE_W    = 20
) (
    input  logic        Clock,
    input  logic        clr,
    input  logic        start_stop,
    input  logic        lap,
    input  logic        zero,
    output logic [15:0] digits,
    output logic        running,
    output logic        lap_active,
    output logic        tick,
    output logic        wrap
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2,
        LAP  = 2'd3
    } state_t;

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);

    state_t           state;
    state_t           state_next;
    logic [2:0]       btn_s1;
    logic [2:0]       btn_s2;
    logic [2:0]       btn_p;
    logic [2:0]       btn_e;
    logic             e_start_stop;
    logic             e_lap;
    logic             e_zero;
    logic [PRE_W-1:0] pre;
    logic [15:0]      count;
    logic [15:0]      count_inc;
    logic [15:0]      lap_reg;
    logic             lap_capture;
    logic             count_clear;

    // Bit order {start_stop, lap, zero}; a held button yields one pulse from s2 & ~p.
    always_ff @(posedge Clock or negedge clr) begin
        if (!clr) begin
            btn_s1 <= '0;
            btn_s2 <= '0;
            btn_p  <= '0;
        end else begin
            btn_s1 <= {start_stop, lap, zero};
            btn_s2 <= btn_s1;
            btn_p  <= btn_s2;
        end
    end

    assign btn_e        = btn_s2 & ~btn_p;
    assign e_start_stop = btn_e[2];
    assign e_lap        = btn_e[1];
    assign e_zero       = btn_e[0];

    always_ff @(posedge Clock or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_next;
    end

    // start_stop outranks lap, which outranks zero.
    always_comb begin
        state_next  = state;
        lap_capture = 1'b0;
        count_clear = 1'b0;
        case (state)
            IDLE: if (e_start_stop) state_next = RUN;
            RUN: begin
                if (e_start_stop) state_next = STOP;
                else if (e_lap) begin
                    state_next  = LAP;
                    lap_capture = 1'b1;
                end
            end
            LAP: begin
                if (e_start_stop) state_next = STOP;
                else if (e_lap)   state_next = RUN;
            end
            STOP: begin
                if (e_start_stop) state_next = RUN;
                else if (e_zero) begin
                    state_next  = IDLE;
                    count_clear = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign running    = (state == RUN) | (state == LAP);
    assign lap_active = (state == LAP);
    assign tick       = running & (pre == PRE_MAX);
    assign wrap       = tick & (count == 16'h5999);

    // Prescaler holds in STOP so a paused partial hundredth is kept.
    always_ff @(posedge Clock or negedge clr) begin
        if (!clr)                              pre <= '0;
        else if (count_clear || state == IDLE) pre <= '0;
        else if (running)                      pre <= tick ? '0 : pre + PRE_W'(1);
    end

    always_comb begin
        count_inc = count;
        if (count[3:0] != 4'd9) count_inc[3:0] = count[3:0] + 4'd1;
        else begin
            count_inc[3:0] = 4'd0;
            if (count[7:4] != 4'd9) count_inc[7:4] = count[7:4] + 4'd1;
            else begin
                count_inc[7:4] = 4'd0;
                if (count[11:8] != 4'd9) count_inc[11:8] = count[11:8] + 4'd1;
                else begin
                    count_inc[11:8] = 4'd0;
                    if (count[15:12] != 4'd5) count_inc[15:12] = count[15:12] + 4'd1;
                    else                      count_inc[15:12] = 4'd0;
                end
            end
        end
    end

    always_ff @(posedge Clock or negedge clr) begin
        if (!clr) begin
            count   <= '0;
            lap_reg <= '0;
        end else begin
            if (count_clear) count <= '0;
            else if (tick)   count <= count_inc;
            if (lap_capture) lap_reg <= count;
        end
    end

    assign digits = lap_active ? lap_reg : count;

endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: cycle-level scoreboard against an elapsed-time model kept in hundredths.
// The model pushes expected outputs at each rising edge; the monitor pops and compares at the falling edge.
module tb_stopwatch_core;

    localparam int TICK_DIV = 4;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_STOP = 2;
    localparam int M_LAP  = 3;

    logic        Clock      = 1'b0;
    logic        clr        = 1'b0;
    logic        start_stop = 1'b0;
    logic        lap        = 1'b0;
    logic        zero       = 1'b0;
    logic [15:0] digits;
    logic        running;
    logic        lap_active;
    logic        tick;
    logic        wrap;

    logic [19:0] exp_q[$];
    int tests_run    = 0;
    int tests_failed = 0;
    int wraps_seen   = 0;
    int wraps_expected = 0;

    // Reference model: mode, elapsed hundredths modulo one minute, lap snapshot, tick phase.
    int m_mode  = M_IDLE;
    int m_live  = 0;
    int m_lap   = 0;
    int m_phase = 0;
    // Button levels sampled 1, 2 and 3 rising edges ago ({start_stop, lap, zero}).
    logic [2:0] h1 = 3'b0;
    logic [2:0] h2 = 3'b0;
    logic [2:0] h3 = 3'b0;

    stopwatch_core #(.TICK_DIV(TICK_DIV), .PRE_W(20)) dut (
        .Clock      (Clock),
        .clr        (clr),
        .start_stop (start_stop),
        .lap        (lap),
        .zero       (zero),
        .digits     (digits),
        .running    (running),
        .lap_active (lap_active),
        .tick       (tick),
        .wrap       (wrap)
    );

    always #5 Clock = ~Clock;

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    function automatic logic [19:0] model_outputs();
        logic mv, t, w;
        mv = (m_mode == M_RUN) || (m_mode == M_LAP);
        t  = mv && (m_phase == TICK_DIV - 1);
        w  = t && (m_live == 5999);
        return {to_bcd(m_mode == M_LAP ? m_lap : m_live), mv, (m_mode == M_LAP), t, w};
    endfunction

    task automatic model_reset();
        m_mode  = M_IDLE;
        m_live  = 0;
        m_lap   = 0;
        m_phase = 0;
        h1 = 3'b0;
        h2 = 3'b0;
        h3 = 3'b0;
    endtask

    // A button is acted on at the third rising edge after its level first rises.
    task automatic model_step(input logic [2:0] lvl);
        logic [2:0] pr;
        int old_live;
        pr = h2 & ~h3;
        old_live = m_live;
        if (m_mode == M_RUN || m_mode == M_LAP) begin
            if (m_phase == TICK_DIV - 1) begin
                m_phase = 0;
                m_live  = (m_live + 1) % 6000;
            end else m_phase = m_phase + 1;
        end
        case (m_mode)
            M_IDLE: if (pr[2]) m_mode = M_RUN;
            M_RUN: begin
                if (pr[2]) m_mode = M_STOP;
                else if (pr[1]) begin
                    m_mode = M_LAP;
                    m_lap  = old_live;
                end
            end
            M_LAP: begin
                if (pr[2])      m_mode = M_STOP;
                else if (pr[1]) m_mode = M_RUN;
            end
            default: begin
                if (pr[2]) m_mode = M_RUN;
                else if (pr[0]) begin
                    m_mode  = M_IDLE;
                    m_live  = 0;
                    m_phase = 0;
                end
            end
        endcase
        h3 = h2;
        h2 = h1;
        h1 = lvl;
    endtask

    always @(posedge Clock) begin : model_proc
        logic [19:0] e;
        if (!clr) begin
            model_reset();
            exp_q.push_back(20'h0);
        end else begin
            model_step({start_stop, lap, zero});
            e = model_outputs();
            if (e[0]) wraps_expected++;
            exp_q.push_back(e);
        end
    end

    // An asynchronous reset voids any expectation not yet compared.
    always @(negedge clr) begin
        model_reset();
        exp_q.delete();
        if (Clock) exp_q.push_back(20'h0);
    end

    always @(negedge Clock) begin : monitor
        logic [19:0] act, e;
        act = {digits, running, lap_active, tick, wrap};
        if (wrap) wraps_seen++;
        tests_run++;
        if (exp_q.size() == 0) begin
            tests_failed++;
            $display("FAIL queue_empty t=%0t: got %h, required a pending expectation", $time, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                tests_failed++;
                $display("FAIL outputs t=%0t: got digits=%h run=%b lap=%b tick=%b wrap=%b, required digits=%h run=%b lap=%b tick=%b wrap=%b",
                         $time, act[19:4], act[3], act[2], act[1], act[0], e[19:4], e[3], e[2], e[1], e[0]);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    task automatic press(input logic [2:0] which, input int hold);
        {start_stop, lap, zero} = {start_stop, lap, zero} | which;
        step(hold);
        {start_stop, lap, zero} = {start_stop, lap, zero} & ~which;
        step(4);
    endtask

    task automatic do_reset();
        clr = 1'b0;
        step(3);
        clr = 1'b1;
        step(1);
    endtask

    initial begin
        step(5);
        clr = 1'b1;
        step(2);

        // Start, then lap near 00.12, release lap about 20 ticks later.
        press(3'b100, 10);
        step(38);
        press(3'b010, $urandom_range(1, 4));
        step(76);
        press(3'b010, 2);
        step($urandom_range(10, 30));

        // Stop, pause, zero, then zero is ignored in IDLE and RUN.
        press(3'b100, 2);
        step(40);
        press(3'b001, 3);
        press(3'b001, 2);
        press(3'b100, 2);
        step(20);
        press(3'b001, 5);
        step(20);

        // start_stop and lap together in RUN, then a long hold of start_stop.
        press(3'b110, 3);
        step(10);
        press(3'b100, 100);
        step(10);

        // Run through 09.99 and 59.99 up to the minute wrap.
        step(24100);
        press(3'b100, 2);

        // Randomized button activity.
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 11) == 0) start_stop = ~start_stop;
            if ($urandom_range(0, 9) == 0)  lap = ~lap;
            if ($urandom_range(0, 9) == 0)  zero = ~zero;
            step(1);
        end
        {start_stop, lap, zero} = 3'b000;
        step(5);

        // Asynchronous reset in LAP around 00.37, asserted between edges.
        do_reset();
        press(3'b100, 2);
        step(140);
        press(3'b010, 2);
        step(20);
        #1;
        clr = 1'b0;
        #1;
        check("async_reset_outputs", {12'h0, digits, running, lap_active, tick, wrap}, 32'h0);
        step(3);
        clr = 1'b1;
        step(2);
        press(3'b010, 2);
        press(3'b001, 2);
        step(30);

        check("wrap_pulse_count", wraps_seen, wraps_expected);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
